// File: rtl/ttt_game_ctrl_pkg.sv
// Shared definitions for the tic-tac-toe game controller: symbol codes,
// FSM state encoding, probe filler pattern and board geometry.
// Also holds a small helper that reads one 2-bit cell out of a board vector.
package ttt_game_ctrl_pkg;

    localparam logic [1:0] EMPTY     = 2'b00;
    localparam logic [1:0] SYM_X     = 2'b01;
    localparam logic [1:0] SYM_O     = 2'b10;
    localparam logic [1:0] PROBE_OWN = 2'b11;

    localparam int NUM_CELLS = 9;

    // Cells 0..8 = 01,01,10,10,10,01,01,01,10; cell k sits at [2k +: 2].
    // No row, column or diagonal of this pattern is a single symbol, so a
    // checker driven by a probe only fires on a line of PROBE_OWN cells.
    localparam logic [17:0] FILLER = 18'b10_01_01_01_10_10_10_01_01;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_MOVE = 2'd1,
        ST_EVAL      = 2'd2,
        ST_OVER      = 2'd3
    } state_t;

    // Symbol stored in cell idx; out-of-range indices read as EMPTY.
    function automatic logic [1:0] cell_of(input logic [17:0] board,
                                           input logic [3:0]  idx);
        logic [1:0] sym;
        sym = EMPTY;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (idx == 4'(k)) sym = board[2*k +: 2];
        end
        return sym;
    endfunction

endpackage

// File: rtl/ttt_game_ctrl_win_chk.sv
// Combinational three-in-a-row checker over a 9-cell, 2-bit-per-cell board.
// Latency: zero (pure combinational). No handshake, no backpressure.
// Ports: i_sym board (cell k at [2k +: 2]); o_win any non-empty uniform line;
//        o_pos {2*a, 2*b, 2*c} of the first matching line (rows, cols, diag, anti).
module ttt_game_ctrl_win_chk
    import ttt_game_ctrl_pkg::*;
(
    input  logic [17:0] i_sym,
    output logic        o_win,
    output logic [14:0] o_pos
);

    // Line table in priority order: rows 0..2, columns 0..2, main, anti.
    localparam int LA [8] = '{0, 3, 6, 0, 1, 2, 0, 2};
    localparam int LB [8] = '{1, 4, 7, 3, 4, 5, 4, 4};
    localparam int LC [8] = '{2, 5, 8, 6, 7, 8, 8, 6};

    always_comb begin
        logic       found;
        logic [1:0] a, b, c;
        found = 1'b0;
        o_pos = '0;
        a     = EMPTY;
        b     = EMPTY;
        c     = EMPTY;
        for (int l = 0; l < 8; l++) begin
            a = i_sym[2*LA[l] +: 2];
            b = i_sym[2*LB[l] +: 2];
            c = i_sym[2*LC[l] +: 2];
            if (!found && (a != EMPTY) && (a == b) && (b == c)) begin
                found = 1'b1;
                o_pos = {5'(2*LA[l]), 5'(2*LB[l]), 5'(2*LC[l])};
            end
        end
        o_win = found;
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Turn scheduler and board owner for tic-tac-toe; latches game result.
// Latency: accept->ack/board 1 clk, result or turn toggle 1 clk later.
// Backpressure: requests held until ack/reject; ignored outside WAIT_MOVE.
// Ports: Clock/Reset (async active-low), iStart, per-player valid+cell,
//        acks, reject, board, turn, game-over/winner/draw/win-line, timeout.
// Optional per-turn timeout enabled by defining GAME_CTRL_TIMEOUT_EN.
module ttt_game_ctrl
    import ttt_game_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
)(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iStart,
    input  logic        iP0Valid,
    input  logic        iP1Valid,
    input  logic [3:0]  iP0Cell,
    input  logic [3:0]  iP1Cell,
    output logic        oP0Ack,
    output logic        oP1Ack,
    output logic        oReject,
    output logic [0:17] oSymVector,
    output logic        oTurn,
    output logic        oGameOver,
    output logic [1:0]  oWinner,
    output logic        oDraw,
    output logic [14:0] oWinSeqPos,
    output logic        oTimeout
);

    state_t      r_state;
    logic [17:0] r_board;
    logic [3:0]  r_cnt;
    logic        r_turn;
    logic        r_p0_ack, r_p1_ack, r_reject;
    logic [1:0]  r_winner;
    logic        r_draw;
    logic [14:0] r_win_pos;

    // Only the player whose turn it is gets looked at.
    logic        w_req_vld;
    logic [3:0]  w_req_cell;
    logic        w_legal;
    logic        w_accept;
    logic [1:0]  w_mover_sym;
    logic [17:0] w_probe;
    logic        w_win;
    logic [14:0] w_win_pos;

    assign w_req_vld   = r_turn ? iP1Valid : iP0Valid;
    assign w_req_cell  = r_turn ? iP1Cell  : iP0Cell;
    assign w_legal     = (w_req_cell <= 4'd8) && (cell_of(r_board, w_req_cell) == EMPTY);
    assign w_accept    = (r_state == ST_WAIT_MOVE) && w_req_vld && w_legal;
    assign w_mover_sym = r_turn ? SYM_O : SYM_X;

    // Mover's cells become PROBE_OWN, everything else the line-free filler.
    always_comb begin
        w_probe = FILLER;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (r_board[2*k +: 2] == w_mover_sym) w_probe[2*k +: 2] = PROBE_OWN;
        end
    end

    ttt_game_ctrl_win_chk u_win_chk (
        .i_sym (w_probe),
        .o_win (w_win),
        .o_pos (w_win_pos)
    );

`ifdef GAME_CTRL_TIMEOUT_EN
    logic [31:0] r_tcnt;
    logic        r_timeout;
`else
    logic        w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_board   <= '0;
            r_cnt     <= '0;
            r_turn    <= 1'b0;
            r_p0_ack  <= 1'b0;
            r_p1_ack  <= 1'b0;
            r_reject  <= 1'b0;
            r_winner  <= EMPTY;
            r_draw    <= 1'b0;
            r_win_pos <= '0;
`ifdef GAME_CTRL_TIMEOUT_EN
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_p0_ack  <= 1'b0;
            r_p1_ack  <= 1'b0;
            r_reject  <= 1'b0;
`ifdef GAME_CTRL_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (iStart) begin
                r_state   <= ST_WAIT_MOVE;
                r_board   <= '0;
                r_cnt     <= '0;
                r_turn    <= 1'b0;
                r_winner  <= EMPTY;
                r_draw    <= 1'b0;
                r_win_pos <= '0;
`ifdef GAME_CTRL_TIMEOUT_EN
                r_tcnt    <= '0;
`endif
            end else begin
                case (r_state)
                    ST_WAIT_MOVE: begin
                        if (w_accept) begin
                            for (int k = 0; k < NUM_CELLS; k++) begin
                                if (w_req_cell == 4'(k)) r_board[2*k +: 2] <= w_mover_sym;
                            end
                            r_cnt    <= r_cnt + 4'd1;
                            r_p0_ack <= ~r_turn;
                            r_p1_ack <= r_turn;
                            r_state  <= ST_EVAL;
                        end else if (w_req_vld) begin
                            r_reject <= 1'b1;
                        end
`ifdef GAME_CTRL_TIMEOUT_EN
                        // An accept in the expiry cycle wins over the forfeit.
                        if (!w_accept) begin
                            if (r_tcnt == TIMEOUT_CYCLES - 1) begin
                                r_timeout <= 1'b1;
                                r_turn    <= ~r_turn;
                                r_tcnt    <= '0;
                            end else begin
                                r_tcnt    <= r_tcnt + 32'd1;
                            end
                        end
`endif
                    end
                    ST_EVAL: begin
                        if (w_win) begin
                            r_state   <= ST_OVER;
                            r_winner  <= w_mover_sym;
                            r_win_pos <= w_win_pos;
                        end else if (r_cnt == 4'(NUM_CELLS)) begin
                            r_state   <= ST_OVER;
                            r_draw    <= 1'b1;
                        end else begin
                            r_turn    <= ~r_turn;
                            r_state   <= ST_WAIT_MOVE;
`ifdef GAME_CTRL_TIMEOUT_EN
                            r_tcnt    <= '0;
`endif
                        end
                    end
                    ST_IDLE, ST_OVER: ;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        oSymVector = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            oSymVector[2*k +: 2] = r_board[2*k +: 2];
        end
    end

    assign oP0Ack     = r_p0_ack;
    assign oP1Ack     = r_p1_ack;
    assign oReject    = r_reject;
    assign oTurn      = r_turn;
    assign oGameOver  = (r_state == ST_OVER);
    assign oWinner    = r_winner;
    assign oDraw      = r_draw;
    assign oWinSeqPos = r_win_pos;
`ifdef GAME_CTRL_TIMEOUT_EN
    assign oTimeout   = r_timeout;
`else
    assign oTimeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_game_ctrl.sv
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        p0v = 1'b0, p1v = 1'b0;
    logic [3:0]  p0c = 4'd0, p1c = 4'd0;
    logic        ack0, ack1, rej, turn, over, draw, tmo;
    logic [1:0]  win;
    logic [0:17] sym;
    logic [14:0] pos;

    always #5 clk = ~clk;

    ttt_game_ctrl #(.TIMEOUT_CYCLES(8)) u_dut (
        .Clock      (clk),
        .Reset      (rst_n),
        .iStart     (start),
        .iP0Valid   (p0v),
        .iP1Valid   (p1v),
        .iP0Cell    (p0c),
        .iP1Cell    (p1c),
        .oP0Ack     (ack0),
        .oP1Ack     (ack1),
        .oReject    (rej),
        .oSymVector (sym),
        .oTurn      (turn),
        .oGameOver  (over),
        .oWinner    (win),
        .oDraw      (draw),
        .oWinSeqPos (pos),
        .oTimeout   (tmo)
    );

    typedef struct {
        logic        st, p0v;
        logic [3:0]  p0c;
        logic        p1v;
        logic [3:0]  p1c;
        logic        ack0, ack1, rej, turn, over;
        logic [1:0]  win;
        logic        draw;
        logic [14:0] pos;
        logic        tmo;
        logic [17:0] board;
    } vec_t;

    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam logic [14:0] POS_ROW0 = 15'd68;  // {5'd0, 5'd2, 5'd4}

    vec_t        vq[$];
    logic [17:0] eb;
    int          total = 0;
    int          bad = 0;

    task automatic put(input int k, input logic [1:0] s);
        eb[2*k +: 2] = s;
    endtask

    task automatic row(input logic st, input logic pv0, input logic [3:0] pc0,
                       input logic pv1, input logic [3:0] pc1,
                       input logic a0, input logic a1, input logic rj,
                       input logic tn, input logic ov, input logic [1:0] wn,
                       input logic dr, input logic [14:0] ps, input logic to);
        vec_t v;
        v.st = st; v.p0v = pv0; v.p0c = pc0; v.p1v = pv1; v.p1c = pc1;
        v.ack0 = a0; v.ack1 = a1; v.rej = rj; v.turn = tn; v.over = ov;
        v.win = wn; v.draw = dr; v.pos = ps; v.tmo = to; v.board = eb;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [17:0] board_now();
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = sym[2*k +: 2];
        return b;
    endfunction

    task automatic chk_all_zero(input string tag, input int idx);
        chk({tag, "_ack0"},  idx, 32'(ack0), 0);
        chk({tag, "_ack1"},  idx, 32'(ack1), 0);
        chk({tag, "_rej"},   idx, 32'(rej),  0);
        chk({tag, "_turn"},  idx, 32'(turn), 0);
        chk({tag, "_over"},  idx, 32'(over), 0);
        chk({tag, "_win"},   idx, 32'(win),  0);
        chk({tag, "_draw"},  idx, 32'(draw), 0);
        chk({tag, "_pos"},   idx, 32'(pos),  0);
        chk({tag, "_tmo"},   idx, 32'(tmo),  0);
        chk({tag, "_board"}, idx, 32'(board_now()), 0);
    endtask

    initial begin
        int mv [9];
        mv = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

        // ---------------- vector table ----------------
        eb = '0;
        row(0, 1,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);          // IDLE ignores requests
        row(1, 0,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);          // start
        put(0, X); row(0, 1,0, 0,0, 1,0,0, 0,0,2'b00,0,0,0);
        row(0, 0,0, 1,5, 0,0,0, 1,0,2'b00,0,0,0);          // EVAL: O request ignored
        put(3, O); row(0, 0,0, 1,3, 0,1,0, 1,0,2'b00,0,0,0);
        row(0, 0,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);
        put(1, X); row(0, 1,1, 0,0, 1,0,0, 0,0,2'b00,0,0,0);
        row(0, 0,0, 0,0, 0,0,0, 1,0,2'b00,0,0,0);
        put(4, O); row(0, 0,0, 1,4, 0,1,0, 1,0,2'b00,0,0,0);
        row(0, 0,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);
        put(2, X); row(0, 1,2, 0,0, 1,0,0, 0,0,2'b00,0,0,0);
        row(0, 0,0, 0,0, 0,0,0, 0,1,X,0,POS_ROW0,0);       // X wins row 0
        row(0, 1,5, 1,6, 0,0,0, 0,1,X,0,POS_ROW0,0);       // OVER ignores
        eb = '0;
        row(1, 1,7, 0,0, 0,0,0, 0,0,2'b00,0,0,0);          // start in OVER + request
        put(4, X); row(0, 1,4, 0,0, 1,0,0, 0,0,2'b00,0,0,0);
        row(0, 0,0, 0,0, 0,0,0, 1,0,2'b00,0,0,0);          // single move: not over
        row(0, 0,0, 1,4, 0,0,1, 1,0,2'b00,0,0,0);          // occupied
        row(0, 0,0, 1,4, 0,0,1, 1,0,2'b00,0,0,0);          // reject repeats
        row(0, 1,0, 1,9, 0,0,1, 1,0,2'b00,0,0,0);          // out of range; P0 ignored
        put(0, O); row(0, 0,0, 1,0, 0,1,0, 1,0,2'b00,0,0,0);
        row(0, 0,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);
        eb = '0;
        row(1, 1,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);          // start beats request
        row(0, 0,0, 1,3, 0,0,0, 0,0,2'b00,0,0,0);          // P1 out of turn
        for (int i = 0; i < 9; i++) begin
            logic o_turn;
            o_turn = logic'(i % 2);
            put(mv[i], o_turn ? O : X);
            row(0, !o_turn, 4'(mv[i]), o_turn, 4'(mv[i]),
                !o_turn, o_turn, 0, o_turn, 0, 2'b00, 0, 0, 0);
            if (i < 8) row(0, 0,0, 0,0, 0,0,0, !o_turn,0,2'b00,0,0,0);
            else       row(0, 0,0, 0,0, 0,0,0, 0,1,2'b00,1,0,0);
        end
        row(0, 1,0, 0,0, 0,0,0, 0,1,2'b00,1,0,0);          // OVER after draw
`ifdef GAME_CTRL_TIMEOUT_EN
        eb = '0;
        row(1, 0,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);
        for (int i = 1; i <= 7; i++) row(0, 0,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);
        row(0, 0,0, 0,0, 0,0,0, 1,0,2'b00,0,0,1);          // 8th idle cycle: forfeit
        for (int i = 1; i <= 7; i++) row(0, 0,0, 0,0, 0,0,0, 1,0,2'b00,0,0,0);
        put(2, O); row(0, 0,0, 1,2, 0,1,0, 1,0,2'b00,0,0,0); // accept beats expiry
        row(0, 0,0, 0,0, 0,0,0, 0,0,2'b00,0,0,0);
`endif

        // ---------------- reset state ----------------
        #1;
        chk_all_zero("reset", 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- apply table ----------------
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            start = vq[i].st;
            p0v = vq[i].p0v; p0c = vq[i].p0c;
            p1v = vq[i].p1v; p1c = vq[i].p1c;
            @(posedge clk);
            #1;
            chk("ack0",  i, 32'(ack0), 32'(vq[i].ack0));
            chk("ack1",  i, 32'(ack1), 32'(vq[i].ack1));
            chk("rej",   i, 32'(rej),  32'(vq[i].rej));
            chk("turn",  i, 32'(turn), 32'(vq[i].turn));
            chk("over",  i, 32'(over), 32'(vq[i].over));
            chk("win",   i, 32'(win),  32'(vq[i].win));
            chk("draw",  i, 32'(draw), 32'(vq[i].draw));
            chk("pos",   i, 32'(pos),  32'(vq[i].pos));
            chk("tmo",   i, 32'(tmo),  32'(vq[i].tmo));
            chk("board", i, 32'(board_now()), 32'(vq[i].board));
        end

        // ---------------- reset during EVAL ----------------
        @(negedge clk);
        start = 1'b1; p0v = 1'b0; p1v = 1'b0;
        @(negedge clk);
        start = 1'b0; p0v = 1'b1; p0c = 4'd0;
        @(posedge clk);
        #1;
        chk("mid_ack", 0, 32'(ack0), 1);
        @(negedge clk);
        p0v = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst", 1);
        @(negedge clk);
        rst_n = 1'b1;
        p0v = 1'b1; p0c = 4'd4;
        @(posedge clk);
        #1;
        chk_all_zero("post_rst_idle", 2);
        @(negedge clk);
        p0v = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
